// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/scoreboard unit: op classes and
// operand-forwarding select codes.
package hazard_pkg;

  typedef enum logic [2:0] {
    OPT_NONE  = 3'd0,
    OPT_ALU   = 3'd1,
    OPT_LOAD  = 3'd2,
    OPT_STORE = 3'd3,
    OPT_MCU   = 3'd4
  } optype_e;

  localparam logic [1:0] FWD_RF       = 2'd0;
  localparam logic [1:0] FWD_EX_ALU   = 2'd1;
  localparam logic [1:0] FWD_MEM_ALU  = 2'd2;
  localparam logic [1:0] FWD_MEM_LOAD = 2'd3;

  // An EX entry that cannot supply a value lets an older MEM match through.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input optype_e opt_exe, input optype_e opt_mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_hit && opt_exe == OPT_ALU)        sel = FWD_EX_ALU;
    else if (mem_hit && opt_mem == OPT_ALU)  sel = FWD_MEM_ALU;
    else if (mem_hit && opt_mem == OPT_LOAD) sel = FWD_MEM_LOAD;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle: decode operand info, downstream destinations, MCU
// status in; stage enables, stalls, flushes and forward selects out.
// There is no valid/ready pair here: every output is a level that the
// pipeline samples on each rising clock edge.
interface hazard_scoreboard_unit_if #(
  parameter int REG_W       = 5,
  parameter int STALL_CNT_W = 16
);
  logic             Branch_ID;
  logic             rs1use_ID;
  logic             rs2use_ID;
  logic             rd_we_ID;
  logic [2:0]       hazard_optype_ID;
  logic [REG_W-1:0] rd_ID;
  logic [REG_W-1:0] rs1_ID;
  logic [REG_W-1:0] rs2_ID;
  logic [REG_W-1:0] rd_EXE;
  logic [REG_W-1:0] rd_MEM;
  logic [REG_W-1:0] rs2_EXE;
  logic             mcu_busy;
  logic             mcu_wb_valid;
  logic [REG_W-1:0] mcu_wb_rd;
  logic             cmu_stall;

  logic             PC_EN_IF;
  logic             reg_FD_EN;
  logic             reg_FD_stall;
  logic             reg_FD_flush;
  logic             reg_DE_EN;
  logic             reg_DE_flush;
  logic             reg_EM_EN;
  logic             reg_EM_flush;
  logic             reg_MW_EN;
  logic             reg_MW_flush;
  logic [1:0]       forward_ctrl_A;
  logic [1:0]       forward_ctrl_B;
  logic             forward_ctrl_ls;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output Branch_ID, rs1use_ID, rs2use_ID, rd_we_ID, hazard_optype_ID,
           rd_ID, rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE,
           mcu_busy, mcu_wb_valid, mcu_wb_rd, cmu_stall,
    input  PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN,
           reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN, reg_MW_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, stall_cnt
  );

  modport slave (
    input  Branch_ID, rs1use_ID, rs2use_ID, rd_we_ID, hazard_optype_ID,
           rd_ID, rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE,
           mcu_busy, mcu_wb_valid, mcu_wb_rd, cmu_stall,
    output PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN,
           reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN, reg_MW_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, stall_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for in-flight MCU results. x0 has no storage
// and always reads as not pending.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rd_a_idx,
  input  logic [REG_W-1:0] rd_b_idx,
  input  logic [REG_W-1:0] waw_idx,
  output logic             rd_a,
  output logic             rd_b,
  output logic             waw
);

  logic [NREG-1:1] pend;
  logic [NREG-1:0] pend_x0;

  assign pend_x0 = {pend, 1'b0};
  assign rd_a    = pend_x0[rd_a_idx];
  assign rd_b    = pend_x0[rd_b_idx];
  assign waw     = pend_x0[waw_idx];

  // Set is checked first so a same-cycle issue to a retiring register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (set_en && set_idx == REG_W'(i))      pend[i] <= 1'b1;
        else if (clr_en && clr_idx == REG_W'(i)) pend[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection, forwarding control and MCU interlocks for the 5-stage
// core; also tracks op classes in EX/MEM and counts decode stall cycles.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG        = 32,
  parameter int REG_W       = $clog2(NREG),
  parameter int STALL_CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_unit_if.slave bus
);

  optype_e opt_id, opt_exe, opt_mem;
  logic    en, id_stall, load_use, raw, waw_stall, struct_stall, issue;
  logic    ex_a, ex_b, mem_a, mem_b;
  logic    pend_rs1, pend_rs2, pend_rd;
  logic [STALL_CNT_W-1:0] cnt_q;

  assign opt_id = optype_e'(bus.hazard_optype_ID);
  assign en     = ~bus.cmu_stall;

  assign ex_a  = bus.rs1use_ID && bus.rs1_ID != '0 && bus.rs1_ID == bus.rd_EXE;
  assign ex_b  = bus.rs2use_ID && bus.rs2_ID != '0 && bus.rs2_ID == bus.rd_EXE;
  assign mem_a = bus.rs1use_ID && bus.rs1_ID != '0 && bus.rs1_ID == bus.rd_MEM;
  assign mem_b = bus.rs2use_ID && bus.rs2_ID != '0 && bus.rs2_ID == bus.rd_MEM;

  // A store whose only dependence is its data operand picks the load up later
  // through the MEM->EX store-data path instead of stalling.
  assign load_use = opt_exe == OPT_LOAD &&
                    (ex_a || (ex_b && opt_id != OPT_STORE));

  assign raw          = (bus.rs1use_ID && pend_rs1) || (bus.rs2use_ID && pend_rs2);
  assign waw_stall    = bus.rd_we_ID && pend_rd;
  assign struct_stall = opt_id == OPT_MCU && bus.mcu_busy;
  assign id_stall     = load_use || raw || waw_stall || struct_stall;
  assign issue        = opt_id == OPT_MCU && en && !id_stall;

  reg_scoreboard #(.NREG(NREG), .REG_W(REG_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue),
    .set_idx  (bus.rd_ID),
    .clr_en   (bus.mcu_wb_valid),
    .clr_idx  (bus.mcu_wb_rd),
    .rd_a_idx (bus.rs1_ID),
    .rd_b_idx (bus.rs2_ID),
    .waw_idx  (bus.rd_ID),
    .rd_a     (pend_rs1),
    .rd_b     (pend_rs2),
    .waw      (pend_rd)
  );

  assign bus.forward_ctrl_A  = fwd_sel(ex_a, mem_a, opt_exe, opt_mem);
  assign bus.forward_ctrl_B  = fwd_sel(ex_b, mem_b, opt_exe, opt_mem);
  assign bus.forward_ctrl_ls = bus.rs2_EXE == bus.rd_MEM && bus.rd_MEM != '0 &&
                               opt_exe == OPT_STORE && opt_mem == OPT_LOAD;

  assign bus.PC_EN_IF     = en && !id_stall;
  assign bus.reg_FD_EN    = en;
  assign bus.reg_DE_EN    = en;
  assign bus.reg_EM_EN    = en;
  assign bus.reg_MW_EN    = en;
  assign bus.reg_FD_stall = id_stall;
  assign bus.reg_DE_flush = id_stall;
  // A branch resolved on stale operands must not redirect fetch.
  assign bus.reg_FD_flush = bus.Branch_ID && !id_stall;
  assign bus.reg_EM_flush = 1'b0;
  assign bus.reg_MW_flush = 1'b0;
  assign bus.stall_cnt    = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opt_exe <= OPT_NONE;
      opt_mem <= OPT_NONE;
    end else if (!bus.cmu_stall) begin
      if (bus.reg_DE_EN) opt_exe <= bus.reg_DE_flush ? OPT_NONE : opt_id;
      if (bus.reg_EM_EN) opt_mem <= opt_exe;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       cnt_q <= '0;
    else if (id_stall && en && cnt_q != '1)        cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed scenarios for the hazard/scoreboard unit; expected control
// vectors are queued by the driver and checked by a negedge monitor.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int W = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_W(5), .STALL_CNT_W(16)) bus ();

  hazard_scoreboard_unit #(.NREG(32), .REG_W(5), .STALL_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;

  function automatic logic [W-1:0] ev(input logic cmu, input logic stl, input logic fdf,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic ls, input logic [15:0] cnt);
    return {~cmu & ~stl, ~cmu, stl, fdf, ~cmu, stl, ~cmu, 1'b0, ~cmu, 1'b0,
            fa, fb, ls, cnt};
  endfunction

  logic [W-1:0] obs;
  assign obs = {bus.PC_EN_IF, bus.reg_FD_EN, bus.reg_FD_stall, bus.reg_FD_flush,
                bus.reg_DE_EN, bus.reg_DE_flush, bus.reg_EM_EN, bus.reg_EM_flush,
                bus.reg_MW_EN, bus.reg_MW_flush, bus.forward_ctrl_A,
                bus.forward_ctrl_B, bus.forward_ctrl_ls, bus.stall_cnt};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      int           t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_miss++;
        $display("FAIL step%0d: got %h want %h", t, obs, e);
      end
    end
  end

  task automatic set_id(input logic [2:0] op, input logic u1, input logic [4:0] r1,
                        input logic u2, input logic [4:0] r2,
                        input logic we, input logic [4:0] rd);
    bus.hazard_optype_ID = op;
    bus.rs1use_ID = u1; bus.rs1_ID = r1;
    bus.rs2use_ID = u2; bus.rs2_ID = r2;
    bus.rd_we_ID  = we; bus.rd_ID  = rd;
  endtask

  task automatic set_dn(input logic [4:0] re, input logic [4:0] rm, input logic [4:0] r2e);
    bus.rd_EXE = re; bus.rd_MEM = rm; bus.rs2_EXE = r2e;
  endtask

  task automatic push(input int tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.Branch_ID = 0; bus.mcu_busy = 0; bus.mcu_wb_valid = 0; bus.mcu_wb_rd = 0;
    bus.cmu_stall = 0;
    set_id(OPT_NONE, 0, 0, 0, 0, 0, 0);
    set_dn(0, 0, 0);
    @(posedge clk);
    #1;
    push(0, ev(0, 0, 0, 0, 0, 0, 0));
    rst = 0;

    // ALU forwarding from EX then MEM
    set_id(OPT_ALU, 0, 0, 0, 0, 1, 5);  set_dn(0, 0, 0);  push(1, ev(0, 0, 0, 0, 0, 0, 0));
    set_id(OPT_ALU, 1, 5, 0, 0, 1, 9);  set_dn(5, 0, 0);  push(2, ev(0, 0, 0, 1, 0, 0, 0));
    set_id(OPT_NONE, 1, 5, 1, 9, 0, 0); set_dn(9, 5, 0);  push(3, ev(0, 0, 0, 2, 1, 0, 0));
    set_id(OPT_NONE, 1, 9, 0, 0, 0, 0); set_dn(0, 9, 0);  push(4, ev(0, 0, 0, 2, 0, 0, 0));
    set_id(OPT_NONE, 0, 0, 0, 0, 0, 0); set_dn(0, 0, 0);  push(5, ev(0, 0, 0, 0, 0, 0, 0));

    // load-use stall, then the store-data exception
    set_id(OPT_LOAD, 0, 0, 0, 0, 1, 6);   push(6, ev(0, 0, 0, 0, 0, 0, 0));
    set_id(OPT_ALU, 0, 0, 1, 6, 1, 10); set_dn(6, 0, 0);  push(7, ev(0, 1, 0, 0, 0, 0, 0));
    set_dn(0, 6, 0);                                       push(8, ev(0, 0, 0, 0, 3, 0, 1));
    set_id(OPT_LOAD, 0, 0, 0, 0, 1, 6); set_dn(10, 0, 0); push(9, ev(0, 0, 0, 0, 0, 0, 1));
    set_id(OPT_STORE, 1, 0, 1, 6, 0, 0); set_dn(6, 10, 0); push(10, ev(0, 0, 0, 0, 0, 0, 1));
    set_id(OPT_NONE, 0, 0, 0, 0, 0, 0); set_dn(0, 6, 6);  push(11, ev(0, 0, 0, 0, 0, 1, 1));
    set_dn(0, 0, 0);                                       push(12, ev(0, 0, 0, 0, 0, 0, 1));

    // MCU RAW: issue x7, dependent waits 5 cycles, branch held off
    set_id(OPT_MCU, 0, 0, 0, 0, 1, 7);                    push(13, ev(0, 0, 0, 0, 0, 0, 1));
    set_id(OPT_ALU, 1, 7, 0, 0, 1, 11); set_dn(7, 0, 0);
    bus.Branch_ID = 1;                                     push(14, ev(0, 1, 0, 0, 0, 0, 1));
    bus.Branch_ID = 0; set_dn(0, 7, 0);                    push(15, ev(0, 1, 0, 0, 0, 0, 2));
    set_dn(0, 0, 0);                                       push(16, ev(0, 1, 0, 0, 0, 0, 3));
                                                           push(17, ev(0, 1, 0, 0, 0, 0, 4));
    bus.mcu_wb_valid = 1; bus.mcu_wb_rd = 7;               push(18, ev(0, 1, 0, 0, 0, 0, 5));
    bus.mcu_wb_valid = 0; bus.Branch_ID = 1;               push(19, ev(0, 0, 1, 0, 0, 0, 6));
    bus.Branch_ID = 0;
    set_id(OPT_NONE, 0, 0, 0, 0, 0, 0); set_dn(11, 0, 0); push(20, ev(0, 0, 0, 0, 0, 0, 6));

    // WAW on x8, then structural busy
    set_id(OPT_MCU, 0, 0, 0, 0, 1, 8);  set_dn(0, 11, 0); push(21, ev(0, 0, 0, 0, 0, 0, 6));
    set_id(OPT_ALU, 0, 0, 0, 0, 1, 8);  set_dn(8, 0, 0);
    bus.Branch_ID = 1;                                     push(22, ev(0, 1, 0, 0, 0, 0, 6));
    bus.Branch_ID = 0; bus.mcu_wb_valid = 1; bus.mcu_wb_rd = 8;
    set_dn(0, 8, 0);                                       push(23, ev(0, 1, 0, 0, 0, 0, 7));
    bus.mcu_wb_valid = 0; set_dn(0, 0, 0);                 push(24, ev(0, 0, 0, 0, 0, 0, 8));
    set_id(OPT_MCU, 0, 0, 0, 0, 1, 12); set_dn(8, 0, 0);
    bus.mcu_busy = 1;                                      push(25, ev(0, 1, 0, 0, 0, 0, 8));
    bus.mcu_busy = 0; set_dn(0, 8, 0);                     push(26, ev(0, 0, 0, 0, 0, 0, 9));

    // cache freeze while x12 writes back
    set_id(OPT_ALU, 0, 0, 0, 0, 1, 13); set_dn(12, 0, 0); push(27, ev(0, 0, 0, 0, 0, 0, 9));
    bus.cmu_stall = 1; bus.mcu_wb_valid = 1; bus.mcu_wb_rd = 12;
    set_id(OPT_NONE, 1, 12, 1, 13, 0, 0); set_dn(13, 12, 0);
                                                           push(28, ev(1, 1, 0, 0, 1, 0, 9));
    bus.mcu_wb_valid = 0;                                  push(29, ev(1, 0, 0, 0, 1, 0, 9));
                                                           push(30, ev(1, 0, 0, 0, 1, 0, 9));
    bus.cmu_stall = 0;                                     push(31, ev(0, 0, 0, 0, 1, 0, 9));
    set_dn(0, 13, 0);                                      push(32, ev(0, 0, 0, 0, 2, 0, 9));

    // x0 everywhere
    set_id(OPT_MCU, 0, 0, 0, 0, 1, 0);  set_dn(0, 0, 0);  push(33, ev(0, 0, 0, 0, 0, 0, 9));
    set_id(OPT_ALU, 1, 0, 1, 0, 1, 0);                     push(34, ev(0, 0, 0, 0, 0, 0, 9));
    set_id(OPT_LOAD, 1, 0, 0, 0, 1, 0);                    push(35, ev(0, 0, 0, 0, 0, 0, 9));
    set_id(OPT_NONE, 1, 0, 1, 0, 0, 0);                    push(36, ev(0, 0, 0, 0, 0, 0, 9));

    // async reset discards a pending bit and the counter
    set_id(OPT_MCU, 0, 0, 0, 0, 1, 14);                    push(37, ev(0, 0, 0, 0, 0, 0, 9));
    set_id(OPT_ALU, 1, 14, 0, 0, 1, 15); set_dn(14, 0, 0); push(38, ev(0, 1, 0, 0, 0, 0, 9));
    set_dn(0, 0, 0);                                       push(39, ev(0, 1, 0, 0, 0, 0, 10));
    rst = 1;                                               push(40, ev(0, 0, 0, 0, 0, 0, 0));
    rst = 0;                                               push(41, ev(0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Hazard detection and forwarding control for the 5-stage RISC-V core, extended with a per-register scoreboard for a variable-latency multi-cycle unit (MCU: mul/div) that issues from EX and writes back independently. It sits beside the pipeline registers, reads decode-stage operand info and downstream destination registers, and drives every stage enable, stall, flush and forwarding select. It adds MCU RAW/WAW/structural interlocks, stall-gated branch flush, enable-respecting optype tracking, and a saturating stall counter.

## Interface
- `NREG`, 32: architectural registers; x0 is never tracked.
- `REG_W`, 5: register address width, equal to $clog2(`NREG`).
- `STALL_CNT_W`, 16: width of the stall statistics counter.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Branch_ID`  in  1  taken branch or jump resolved in ID.
- `rs1use_ID`, `rs2use_ID`  in  1  ID reads rs1/rs2.
- `rd_we_ID`  in  1  ID instruction writes rd.
- `hazard_optype_ID`  in  3  ID op class; codes come from the package.
- `rd_ID`, `rs1_ID`, `rs2_ID`, `rd_EXE`, `rd_MEM`, `rs2_EXE`  in  `REG_W`  register addresses.
- `mcu_busy`  in  1  MCU cannot accept a new op.
- `mcu_wb_valid`  in  1  MCU writes `mcu_wb_rd` this cycle.
- `mcu_wb_rd`  in  `REG_W`  MCU writeback destination.
- `cmu_stall`  in  1  cache stall; freezes the whole pipeline.
- `PC_EN_IF`, `reg_FD_EN`, `reg_FD_stall`, `reg_FD_flush`, `reg_DE_EN`, `reg_DE_flush`, `reg_EM_EN`, `reg_EM_flush`, `reg_MW_EN`, `reg_MW_flush`  out  1  pipeline control.
- `forward_ctrl_A`, `forward_ctrl_B`  out  2  operand select: 0 regfile, 1 EX ALU, 2 MEM ALU, 3 MEM load data.
- `forward_ctrl_ls`  out  1  forward the MEM load result into the EX store data.
- `stall_cnt`  out  `STALL_CNT_W`  saturating count of cycles with `id_stall` asserted.

## Operation
- Optype codes: NONE=0, ALU=1, LOAD=2, STORE=3, MCU=4.
- Optype pipeline:
  - `optype_EXE` and `optype_MEM` are registers.
  - `optype_EXE` loads when `reg_DE_EN` is high. It takes NONE if `reg_DE_flush` is high, otherwise `hazard_optype_ID`.
  - `optype_MEM` loads `optype_EXE` when `reg_EM_EN` is high.
  - Both registers hold while `cmu_stall` is high.
- Forwarding:
  - EX has priority over MEM.
  - A match requires `rsX_use`, a nonzero rd, and rs equal to rd.
  - EX ALU selects 1. MEM ALU selects 2. MEM LOAD selects 3.
  - MCU, STORE and NONE entries never forward.
- Load-use stall: asserted when an operand matches `rd_EXE` and `optype_EXE` is LOAD, unless the ID op is STORE and only rs2 matches. That case is covered by `forward_ctrl_ls`.
- `forward_ctrl_ls`: asserted when `rs2_EXE` equals `rd_MEM`, `rd_MEM` is nonzero, `optype_EXE` is STORE and `optype_MEM` is LOAD.
- Scoreboard: `pend[NREG-1:1]`.
  - Set bit `rd_ID` when an MCU op issues. Issue means `optype_ID` is MCU, `reg_DE_EN` is high and `id_stall` is low.
  - Clear bit `mcu_wb_rd` when `mcu_wb_valid` is high.
  - If set and clear target the same bit in one cycle, set wins.
  - Writes to x0 are ignored.
- Scoreboard stalls:
  - RAW: a used rs has its pending bit set.
  - WAW: `rd_we_ID` is high and `pend[rd_ID]` is set.
  - Structural: `optype_ID` is MCU and `mcu_busy` is high.
- `id_stall` is the OR of the load-use stall and the three scoreboard stalls.
- There is no MCU result bypass. ID proceeds in the cycle after `pend` clears, and the regfile write is complete by then.
- Control outputs:
  - `reg_FD_EN`, `reg_DE_EN`, `reg_EM_EN` and `reg_MW_EN` equal `~cmu_stall`.
  - `PC_EN_IF` equals `~cmu_stall & ~id_stall`.
  - `reg_FD_stall` equals `id_stall`.
  - `reg_DE_flush` equals `id_stall`; a bubble is inserted.
  - `reg_FD_flush` equals `Branch_ID & ~id_stall`. A branch acts only with valid operands.
  - `reg_EM_flush` and `reg_MW_flush` are 0.
- `stall_cnt`: increments when `id_stall` is high and `cmu_stall` is low. It saturates at all-ones.

## Timing
- Reset, asynchronous:
  - `optype_EXE`, `optype_MEM`, `pend` and `stall_cnt` clear to 0 immediately.
  - With idle inputs, the outputs settle to: `PC_EN_IF`=1, all EN=1, all stall and flush=0, forwards=0.
- All control outputs are combinational from inputs and state, with zero-cycle latency.
- Scoreboard latency:
  - A set is visible in the cycle after issue. A dependent op in the next ID therefore stalls.
  - A clear is visible in the cycle after `mcu_wb_valid`.
- `cmu_stall` is high: no state changes except scoreboard clears. The MCU completes independently.
- Reset mid-operation discards all pending bits. The MCU must be reset on the same `rst`.

## Structure
- Package `hazard_pkg`: optype enum with width 3 and the forward select codes 0..3.
- Sub-module `reg_scoreboard`:
  - Parameters `NREG` and `REG_W`.
  - Inputs: set port, clear port, two read ports, and a WAW read port.
  - Owns `pend`.
- Top level: forwarding and stall logic, the optype pipeline, and the counter.

## Test plan
- ALU x5 in EX, ID uses rs1=x5 -> `forward_ctrl_A`=1, no stall. The same op one cycle later in MEM -> `forward_ctrl_A`=2.
- LOAD x6 in EX, ID ADD rs2=x6 -> one cycle with `PC_EN_IF`=0, `reg_DE_flush`=1, then `forward_ctrl_B`=3. If the ID op is instead STORE with rs2=x6 -> no stall, and next cycle `forward_ctrl_ls`=1.
- MCU op rd=x7 issues, next ID reads x7; `mcu_wb_valid` with rd=7 arrives 4 cycles later -> stall for 5 cycles, `stall_cnt`=5.
- MCU op rd=x8 pending, ID ALU writes x8 -> WAW stall until the clear. `mcu_busy`=1 with an ID MCU op -> stall. `Branch_ID`=1 during any of these stalls -> `reg_FD_flush`=0.
- `cmu_stall`=1 for 3 cycles while an MCU writeback occurs -> optypes hold, the pend bit clears, `stall_cnt` is unchanged. Assert `rst` with pend bits set -> all clear asynchronously.
- rd=x0 in EX, MEM or MCU -> never forwards, never sets pend, never stalls.
